// File: rtl/trng_entropy_collector.sv
// Entropy front end: von Neumann corrector, 32-bit word packer and show-ahead word FIFO.
// Optional repetition-count health test is compiled in with TRNG_HEALTH_TEST_EN.
module trng_entropy_collector #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned RCT_CUTOFF = 32
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic                          enable,
   input  logic                          raw_bit,
   input  logic                          raw_valid,
   output logic [31:0]                   word_data,
   output logic                          word_valid,
   input  logic                          word_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          health_fail,
   input  logic                          clr_fail
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {ST_IDLE, ST_HELD} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic          r_a;
   logic          w_a_next;
   logic          w_bit_valid;

   logic [31:0]   r_sr;
   logic [4:0]    r_cnt;
   logic          w_word_done;
   logic [31:0]   w_word;

   logic [31:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          w_full;
   logic          w_pop;
   logic          w_push;

   logic          w_flush;
   logic          w_push_block;

   // Corrector: hold the first sample of a pair, emit it only if the second differs.
   always_comb begin
      w_state_next = r_state;
      w_a_next     = r_a;
      w_bit_valid  = 1'b0;
      if (!enable) begin
         w_state_next = ST_IDLE;
      end else if (raw_valid) begin
         case (r_state)
            ST_IDLE: begin
               w_a_next     = raw_bit;
               w_state_next = ST_HELD;
            end
            ST_HELD: begin
               w_bit_valid  = (r_a != raw_bit);
               w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state <= ST_IDLE;
         r_a     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_a     <= w_a_next;
      end
   end

`ifdef TRNG_HEALTH_TEST_EN
   logic [7:0] r_run;
   logic [7:0] w_run_next;
   logic       r_last;
   logic       r_health_fail;
   logic       w_rct_fail;

   // Run length saturates so a very long run cannot wrap and re-trigger.
   always_comb begin
      w_run_next = r_run;
      if (enable && raw_valid) begin
         if (r_run == 8'd0 || raw_bit != r_last)
            w_run_next = 8'd1;
         else if (r_run != 8'hFF)
            w_run_next = r_run + 8'd1;
      end
   end

   assign w_rct_fail = enable && raw_valid && !clr_fail &&
                       (w_run_next == 8'(RCT_CUTOFF)) && (r_run != 8'(RCT_CUTOFF));

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_run         <= 8'd0;
         r_last        <= 1'b0;
         r_health_fail <= 1'b0;
      end else begin
         if (enable && raw_valid)
            r_last <= raw_bit;
         if (clr_fail) begin
            r_run         <= 8'd0;
            r_health_fail <= 1'b0;
         end else begin
            r_run <= w_run_next;
            if (w_rct_fail)
               r_health_fail <= 1'b1;
         end
      end
   end

   assign health_fail  = r_health_fail;
   assign w_flush      = w_rct_fail;
   assign w_push_block = r_health_fail;
`else
   logic w_unused;
   assign w_unused     = clr_fail & (RCT_CUTOFF != 0);
   assign health_fail  = 1'b0;
   assign w_flush      = 1'b0;
   assign w_push_block = 1'b0;
`endif

   // Packer: first corrected bit ends up in bit 31 of the finished word.
   assign w_word      = {r_sr[30:0], r_a};
   assign w_word_done = w_bit_valid && (r_cnt == 5'd31);

   always_ff @(posedge ACLK) begin
      if (ARESET || !enable || w_flush) begin
         r_sr  <= 32'd0;
         r_cnt <= 5'd0;
      end else if (w_bit_valid) begin
         r_sr  <= w_word;
         r_cnt <= r_cnt + 5'd1;
      end
   end

   assign w_full = (r_level == LW'(FIFO_DEPTH));
   assign w_pop  = (r_level != '0) && word_ready;
   assign w_push = w_word_done && !w_push_block && !w_flush && (!w_full || w_pop);

   always_ff @(posedge ACLK) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_word;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET || w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign word_valid = (r_level != '0);
   assign word_data  = word_valid ? r_mem[r_rd_ptr] : 32'd0;
   assign fifo_level = r_level;

endmodule

// File: doc/trng_entropy_collector.md
# trng_entropy_collector

Entropy front end for the axi_trng peripheral. It takes a synchronized raw bit stream from the ring-oscillator sampler and removes bias with a von Neumann corrector. It packs the corrected bits into 32-bit words and buffers them in a small show-ahead FIFO. The AXI4-Lite register block pops one word per read of its data register.

## Interface
- FIFO_DEPTH, 4: word FIFO depth; power of two, 2..16.
- RCT_CUTOFF, 32: repetition-count cutoff, counted in identical consecutive raw samples (2..255).
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- enable  in  1  collector enable, from the control register.
- raw_bit  in  1  entropy sample, already synchronized to ACLK.
- raw_valid  in  1  qualifies raw_bit for one cycle.
- word_data  out  32  FIFO head word; forced to 0 while word_valid=0.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  pop strobe from the register block; a pop occurs when word_valid&&word_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of stored words.
- health_fail  out  1  sticky health-test failure.
- clr_fail  in  1  clears health_fail and the repetition counter.

## Operation
- **Corrector FSM: IDLE, HELD.**
  - IDLE, raw_valid&&enable: latch raw_bit as `a`, go to HELD.
  - HELD, raw_valid&&enable: compare `a` with raw_bit.
    - If they differ, emit one corrected bit equal to `a`.
    - If they are equal, discard the pair.
    - In both cases return to IDLE.
- **Packer.**
  - Each corrected bit does sr <= {sr[30:0], bit} and increments a 5-bit count. The first corrected bit ends at bit 31.
  - The bit that brings the count to 32 completes a word. The completed word is {sr[30:0], bit}.
  - On completion the packer pushes the word and the count wraps to 0.
- **FIFO push and pop.**
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the completed word is dropped silently. The packer restarts.
  - Pop and push in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **enable=0.**
  - The FSM is forced to IDLE, and sr and count are cleared.
  - FIFO contents are retained, and pops still work.
- **ARESET=1.**
  - Clears the FSM to IDLE, sr, count, FIFO pointers and the repetition counter, and sets health_fail=0.
  - This applies mid-word and mid-FIFO alike; nothing survives reset.
- **Reset values.**
  - word_data=0, word_valid=0, fifo_level=0, health_fail=0.

## Timing
- A word completed by the raw sample accepted at edge k is pushed at edge k.
  - word_valid=1 and word_data are valid in the cycle after edge k.
  - Latency is 1 cycle from the final sample edge.
- A pop at edge p moves word_data to the next entry, or to 0, in the cycle after p.
- fifo_level updates at the same edge as the push or pop.
- raw_valid may be asserted on every cycle; full throughput is required.
- Corrected output rate is at most one bit per two raw samples.

## Configuration
- Macro: TRNG_HEALTH_TEST_EN.
- **Defined: repetition count test on raw samples.**
  - Counting:
    - The counter tracks the run length of identical accepted raw_bit values while enable=1.
    - A differing bit resets the run length to 1.
  - Failure:
    - When the run length reaches RCT_CUTOFF, health_fail=1 from the next cycle.
    - The FIFO is flushed at the same edge, and sr and count are cleared.
  - While health_fail=1:
    - Pushes are inhibited.
    - Corrector and packer keep running, but completed words are discarded.
  - clr_fail clears the flag and resets the run length to 0. If clr_fail and a failure coincide, clr_fail wins.
- **Undefined.**
  - health_fail is tied to 0. clr_fail and RCT_CUTOFF are ignored.
  - No repetition counter is synthesized.

## Test plan
- ARESET, enable=1, then 32 raw pairs (1,0) -> word_valid one cycle after the last sample, word_data=0xFFFFFFFF, fifo_level=1. Pulse word_ready -> word_valid=0, word_data=0.
- 32 pairs (0,1) interleaved with 10 pairs (1,1) and 10 pairs (0,0) -> exactly one word, 0x00000000. Equal pairs produce no bits.
- word_ready=0, raw pairs forming words 0xA5A5A5A5, 0x5A5A5A5A, 0x12345678, 0xDEADBEEF, 0xCAFEF00D -> fifo_level=4 and the 5th word is dropped. Four pops return the first four words in order.
- FIFO full, the final sample of a new word coincides with a pop -> push accepted, fifo_level stays 4. Subsequent pops return the remaining 3 old words, then the new word.
- After 17 corrected bits, enable=0 for 1 cycle, then enable=1 and 32 pairs (1,0) -> the single word is 0xFFFFFFFF; the partial word is discarded. ARESET mid-word gives the same outcome with fifo_level=0.
- With TRNG_HEALTH_TEST_EN defined, 2 stored words, then 32 consecutive raw 1s -> health_fail=1 the cycle after the 32nd sample, fifo_level=0, no pushes. clr_fail then 32 pairs (1,0) -> a word appears. Without the macro, health_fail remains 0.
